// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
//   Shared constants and types for the video timing generator:
//     - COORD_W / COORD_MAX : width and ceiling of every counter and coordinate
//     - *_720P              : default 1280x720 timing (clocks / lines)
//     - POL_*               : sync polarity encodings
//     - timing_out_t        : the bundle of registered timing outputs
//     - in_window()         : half-open range test used by the decoders
// -----------------------------------------------------------------------------
package video_timing_pkg;

    localparam int COORD_W   = 12;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam logic POL_POSITIVE = 1'b1;
    localparam logic POL_NEGATIVE = 1'b0;

    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               frame_start;
    } timing_out_t;

    // True when lo <= cnt < lo + len.
    function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                       input int lo, input int len);
        return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Modulo-MODULUS up counter with synchronous clear.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous, active-high reset to 0
//     clr    in   synchronous clear to 0 (wins over en)
//     en     in   advance by one this clock
//     count  out  current count, 0..MODULUS-1
//     carry  out  high on the enabled clock that wraps MODULUS-1 -> 0
// -----------------------------------------------------------------------------
module mod_counter
    import video_timing_pkg::*;
#(
    parameter int MODULUS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               carry
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(MODULUS - 1);

    logic [COORD_W-1:0] count_d;
    logic [COORD_W-1:0] count_q;

    // Combinational carry so a chained counter steps on the same edge as the wrap.
    assign carry = en && !clr && (count_q == LAST);

    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = carry ? '0 : count_q + COORD_W'(1);
        end
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge
    // values regardless of process ordering; blocking here would race.
    // NOTE: reset sits in the sensitivity list, so it acts immediately and
    // does not need a running clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator: sync, back porch, active, front porch, both axes.
//   Two chained mod_counters walk (h_cnt, v_cnt); a decoder turns the current
//   position into registered outputs, so all outputs lag the counter state by
//   exactly one clock and stay mutually aligned.
//   Ports:
//     clk          in   pixel clock, rising edge
//     reset        in   asynchronous, active-high reset
//     en           in   run enable; low parks the raster at its origin
//     hs / vs      out  sync, level HS_POL / VS_POL while in sync
//     de           out  active-video data enable
//     x / y        out  active pixel column / row, 0 outside active video
//     frame_start  out  one-clock pulse for position (0,0)
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_720P,
    parameter int   H_FP     = H_FP_720P,
    parameter int   H_SYNC   = H_SYNC_720P,
    parameter int   H_BP     = H_BP_720P,
    parameter int   V_ACTIVE = V_ACTIVE_720P,
    parameter int   V_FP     = V_FP_720P,
    parameter int   V_SYNC   = V_SYNC_720P,
    parameter int   V_BP     = V_BP_720P,
    parameter logic HS_POL   = POL_POSITIVE,
    parameter logic VS_POL   = POL_POSITIVE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int V_ACT_START = V_SYNC + V_BP;

    localparam timing_out_t OUT_IDLE = '{
        hs:          ~HS_POL,
        vs:          ~VS_POL,
        de:          1'b0,
        x:           '0,
        y:           '0,
        frame_start: 1'b0
    };

    // Totals must fit the coordinate width; refuse to elaborate otherwise.
    if (H_TOTAL > COORD_MAX) begin : g_h_total_too_big
        $error("video_timing_gen: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > COORD_MAX) begin : g_v_total_too_big
        $error("video_timing_gen: V_TOTAL exceeds counter range");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    // en low clears both counters on the next clock, so re-enabling always
    // begins at the frame origin.
    mod_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (~en),
        .en    (en),
        .count (h_cnt),
        .carry (h_wrap)
    );

    mod_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (~en),
        .en    (h_wrap),
        .count (v_cnt),
        .carry (v_wrap)
    );

    timing_out_t out_d;
    timing_out_t out_q;
    logic        h_act;
    logic        v_act;

    always_comb begin
        out_d = OUT_IDLE;
        h_act = in_window(h_cnt, H_ACT_START, H_ACTIVE);
        v_act = in_window(v_cnt, V_ACT_START, V_ACTIVE);
        if (en) begin
            out_d.hs = in_window(h_cnt, 0, H_SYNC) ? HS_POL : ~HS_POL;
            // vs decodes v_cnt only, and v_cnt moves only at the h wrap, so vs
            // toggles exactly when hs enters its sync pulse.
            out_d.vs = in_window(v_cnt, 0, V_SYNC) ? VS_POL : ~VS_POL;
            out_d.de = h_act && v_act;
            if (h_act && v_act) begin
                out_d.x = h_cnt - COORD_W'(H_ACT_START);
                out_d.y = v_cnt - COORD_W'(V_ACT_START);
            end
            out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= OUT_IDLE;
        end else begin
            out_q <= out_d;
        end
    end

    assign hs          = out_q.hs;
    assign vs          = out_q.vs;
    assign de          = out_q.de;
    assign x           = out_q.x;
    assign y           = out_q.y;
    assign frame_start = out_q.frame_start;

    // Frame wrap is implied by the counters themselves; nothing consumes it.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule
